// File: rtl/parity_frame_checker.sv
// Parity frame checker: checks per-word parity over a frame of words,
// counts failing words and emits the frame length plus a generated
// parity bit over all data bits, held until the consumer accepts it.
module parity_frame_checker #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 4,
  localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_odd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic [CNT_W-1:0]  out_err_cnt,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_len
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  logic               acc_par;
  logic [CNT_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   acc_err;
  logic               mode_q;

  logic               accept;
  logic               mode_eff;
  logic               word_err;
  logic               nxt_par;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [CNT_W-1:0]   nxt_err;
  logic               frame_end;

  // Next accumulator values for the word offered this cycle; mode comes
  // from the live input only on the first word of a frame.
  always_comb begin
    accept    = in_valid && in_ready;
    mode_eff  = (acc_cnt == '0) ? mode_odd : mode_q;
    word_err  = (^{in_data, in_par}) != mode_eff;
    nxt_par   = acc_par ^ (^in_data);
    nxt_cnt   = acc_cnt + CNT_W'(1);
    nxt_err   = acc_err + CNT_W'(word_err);
    frame_end = in_last || (nxt_cnt == CNT_W'(FRAME_LEN));
  end

  // Frame FSM with accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      in_ready    <= 1'b1;
      acc_par     <= 1'b0;
      acc_cnt     <= '0;
      acc_err     <= '0;
      mode_q      <= 1'b0;
      out_valid   <= 1'b0;
      out_parity  <= 1'b0;
      out_err_cnt <= '0;
      out_err     <= 1'b0;
      out_len     <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            mode_q <= mode_eff;
            if (frame_end) begin
              state       <= HOLD;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_parity  <= nxt_par ^ mode_eff;
              out_err_cnt <= nxt_err;
              out_err     <= (nxt_err != '0);
              out_len     <= nxt_cnt;
              acc_par     <= nxt_par;
              acc_cnt     <= nxt_cnt;
              acc_err     <= nxt_err;
            end else begin
              acc_par <= nxt_par;
              acc_cnt <= nxt_cnt;
              acc_err <= nxt_err;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc_par   <= 1'b0;
            acc_cnt   <= '0;
            acc_err   <= '0;
            mode_q    <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=8, FRAME_LEN=4).
module tb_parity_frame_checker;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

  logic              clk;
  logic              rst_n;
  logic              mode_odd;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic              out_parity;
  logic [CNT_W-1:0]  out_err_cnt;
  logic              out_err;
  logic [CNT_W-1:0]  out_len;

  int checks   = 0;
  int failures = 0;

  parity_frame_checker #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_err_cnt(out_err_cnt),
    .out_err    (out_err),
    .out_len    (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word for exactly one clock edge, then sample 1 time unit later.
  task automatic send(input logic [7:0] d, input logic p, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_par   = 1'bx;
    in_last  = 1'bx;
  endtask

  task automatic check_result(input string tag, input logic v, input logic [CNT_W-1:0] len,
                              input logic [CNT_W-1:0] ecnt, input logic err, input logic par);
    check({tag, "_valid"},  32'(out_valid),   32'(v));
    check({tag, "_len"},    32'(out_len),     32'(len));
    check({tag, "_errcnt"}, 32'(out_err_cnt), 32'(ecnt));
    check({tag, "_err"},    32'(out_err),     32'(err));
    check({tag, "_parity"}, 32'(out_parity),  32'(par));
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode_odd  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_par    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_result("rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Even-mode full frame ends at FRAME_LEN with in_last low
    mode_odd = 1'b0;
    send(8'h02, 1'b1, 1'b0);
    check("even_w1_no_valid", 32'(out_valid), 32'd0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    check("even_w3_ready", 32'(in_ready), 32'd1);
    send(8'hFF, 1'b0, 1'b0);
    check_result("even_full", 1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
    check("even_full_in_ready", 32'(in_ready), 32'd0);
    handshake();
    check("even_hs_valid", 32'(out_valid), 32'd0);
    check("even_hs_ready", 32'(in_ready), 32'd1);
    check("even_hs_len_kept", 32'(out_len), 32'd4);

    // Odd-mode early end with one failing word
    mode_odd = 1'b1;
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    check_result("odd_early", 1'b1, 3'd2, 3'd1, 1'b1, 1'b0);

    // Backpressure: words offered during HOLD must be refused
    mode_odd = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_par   = 1'b0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check_result("bp_hold", 1'b1, 3'd2, 3'd1, 1'b1, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    check_result("bp_rel_kept", 1'b0, 3'd2, 3'd1, 1'b1, 1'b0);
    // A single-word frame now must report length 1 if nothing leaked in HOLD
    send(8'h01, 1'b1, 1'b1);
    check_result("post_bp", 1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
    handshake();

    // Reset mid-frame discards the partial frame
    mode_odd = 1'b1;
    send(8'h07, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check_result("midrst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    mode_odd = 1'b0;
    send(8'h80, 1'b1, 1'b1);
    check_result("after_rst", 1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
    handshake();

    // Mode change mid-frame is ignored: whole frame checked as even
    mode_odd = 1'b0;
    send(8'h01, 1'b1, 1'b0);
    mode_odd = 1'b1;
    send(8'h07, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    check_result("mode_chg", 1'b1, 3'd3, 3'd0, 1'b0, 1'b0);
    handshake();

    // Odd-mode full frame with every word failing
    mode_odd = 1'b1;
    send(8'h00, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    check_result("odd_allerr", 1'b1, 3'd4, 3'd4, 1'b1, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
